// File: rtl/data_mem_alt_pkg.sv
// Shared sizing defaults for the frame-buffer data memory.
// Imported by the storage core and its wrapper.
package data_mem_alt_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/data_mem_alt_dpram_core.sv
// Storage core: word array, write port and registered read port.
// Enables and reset are active-high/active-low logical here.
module dpram_core
  import data_mem_alt_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);

  localparam int DEPTH = depth_of(AW);

  logic [DW-1:0] mem [DEPTH];

  // Read samples the array before this edge's write: read-old-data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (we) begin
        mem[wr_addr] <= wr_data;
      end
      if (re) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_alt.sv
// Frame-buffer data memory: one write port, one registered read port.
// Decodes the active-low enables onto the storage core.
module data_mem_alt
  import data_mem_alt_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic we;
  logic re;

  assign we = ~wr_en;
  assign re = ~rd_en;

  dpram_core #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (reset),
    .we     (we),
    .re     (re),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .wr_data(wr_data),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_data_mem_alt.sv
// Bench for data_mem_alt: vector table plus reset sequences,
// expected read data queued at drive time and checked after the edge.
module tb_data_mem_alt;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  wr_addr;
  logic [2:0]  rd_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;

  int n_vec = 0;
  int n_miss = 0;

  logic [15:0] sb[$];

  typedef struct packed {
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  wa;
    logic [2:0]  ra;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  data_mem_alt #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .wr_data(wr_data),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic we_n, input logic re_n,
                      input logic [2:0] wa, input logic [2:0] ra,
                      input logic [15:0] wd, input logic [15:0] exp);
    logic [15:0] e;
    @(negedge clk);
    wr_en   = we_n;
    rd_en   = re_n;
    wr_addr = wa;
    rd_addr = ra;
    wr_data = wd;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, rd_data, e);
    end
  endtask

  task automatic idle();
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
  endtask

  initial begin
    // wr_en, rd_en, wr_addr, rd_addr, wr_data, expected rd_data
    vecs[0]  = '{1'b0, 1'b1, 3'd0, 3'd0, 16'h0001, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 3'd0, 16'h0002, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 3'd0, 16'h0003, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 3'd0, 16'h0004, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0001};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 3'd1, 16'h0000, 16'h0002};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 3'd2, 16'h0000, 16'h0003};
    vecs[7]  = '{1'b1, 1'b1, 3'd0, 3'd0, 16'h0000, 16'h0003};
    vecs[8]  = '{1'b1, 1'b1, 3'd0, 3'd1, 16'h0000, 16'h0003};
    vecs[9]  = '{1'b0, 1'b1, 3'd5, 3'd3, 16'hAAAA, 16'h0003};
    vecs[10] = '{1'b1, 1'b0, 3'd0, 3'd3, 16'h0000, 16'h0004};
    vecs[11] = '{1'b0, 1'b0, 3'd5, 3'd5, 16'h5555, 16'hAAAA};
    vecs[12] = '{1'b1, 1'b0, 3'd0, 3'd5, 16'h0000, 16'h5555};
    vecs[13] = '{1'b0, 1'b0, 3'd6, 3'd3, 16'h1234, 16'h0004};
    vecs[14] = '{1'b1, 1'b0, 3'd0, 3'd6, 16'h0000, 16'h1234};
    vecs[15] = '{1'b1, 1'b0, 3'd0, 3'd7, 16'h0000, 16'h0000};
    vecs[16] = '{1'b1, 1'b1, 3'd0, 3'd0, 16'hBEEF, 16'h0000};
    vecs[17] = '{1'b0, 1'b0, 3'd7, 3'd0, 16'hFFFF, 16'h0001};
    vecs[18] = '{1'b1, 1'b0, 3'd0, 3'd7, 16'h0000, 16'hFFFF};

    // Reset held with an enabled write: nothing may land.
    reset   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = 3'd0;
    rd_addr = 3'd0;
    wr_data = 16'h0001;
    #1;
    check("reset_rd_data_async", rd_data, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_rd_data_edge", rd_data, 16'h0000);
    @(negedge clk);
    idle();
    reset = 1'b1;
    step("post_reset_rd0", 1'b1, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000);

    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), vecs[i].wr_en, vecs[i].rd_en,
           vecs[i].wa, vecs[i].ra, vecs[i].wd, vecs[i].exp);
    end

    // Async reset between edges while rd_data is non-zero.
    #2;
    reset = 1'b0;
    #1;
    check("midrun_reset_async", rd_data, 16'h0000);
    step("reset_ignores_access", 1'b0, 1'b0, 3'd0, 3'd7, 16'h9999, 16'h0000);
    @(negedge clk);
    idle();
    reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      step($sformatf("post_midrun_rd%0d", a), 1'b1, 1'b0, 3'd0,
           3'(a), 16'h0000, 16'h0000);
    end
    step("post_midrun_rd7", 1'b1, 1'b0, 3'd0, 3'd7, 16'h0000, 16'h0000);
    step("post_midrun_rd5", 1'b1, 1'b0, 3'd0, 3'd5, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
